sseg_ctrl: RTL and testbench
============================

// Module: sseg_ctrl
// PURPOSE
//  Display-ownership controller in front of the 4-digit seven-segment driver.
//  Two requesters (A, B) offer 16-bit hex words via valid/ready; block arbitrates
//  round-robin, latches the winner's word onto digit3..digit0, and generates the
//  one-cycle refresh strobe that drives the driver's digit-scan enable input.
//  Optional hold timer guarantees a winner stays on screen for a minimum time.
// PARAMETERS
//  REFRESH_DIV  100_000  clk cycles per refresh strobe (>=2); 1 kHz scan @100 MHz
//  HOLD_TICKS   250      refresh strobes an owner is held (>=1), HOLD feature only
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  a_valid      in   1   requester A offers a_data
//  a_data       in   16  A word: [15:12]=digit3 .. [3:0]=digit0
//  a_ready      out  1   A transfer accepted this cycle when a_valid&&a_ready
//  b_valid      in   1   requester B offers b_data
//  b_data       in   16  B word, same packing
//  b_ready      out  1   B accept, as a_ready
//  digit3..0    out  4ea registered hex digits to the display driver
//  refresh_en   out  1   one-cycle strobe to the driver's scan enable
//  owner        out  1   0=A, 1=B: source of currently shown digits
//  busy         out  1   1 while in HOLD
// BEHAVIOUR
//  Reset: digits=0, refresh_en=0, owner=0, busy=0, ready=0, prescaler=0,
//   state=IDLE, last_grant=B (A wins first tie). Reset mid-HOLD -> IDLE, digits 0.
//  Prescaler: cnt 0..REFRESH_DIV-1 wraps; refresh_en=1 exactly in cycle after
//   cnt==REFRESH_DIV-1, i.e. one pulse per REFRESH_DIV cycles; free-running.
//  Handshake: ready is combinational from state/valids/last_grant, never
//   depends on data. Transfer iff valid&&ready. Requester keeps valid and data
//   stable until transfer; dropping valid earlier captures nothing.
//  Arbitration (IDLE): only one requester valid -> it is granted. Both valid ->
//   the one not equal to last_grant wins. At most one ready high per cycle.
//  Transfer latency: digits/owner update on the clk edge ending the transfer
//   cycle (visible next cycle); last_grant <= winner.
//  FSM (SSEG_CTRL_HOLD_EN defined): IDLE, HOLD.
//   IDLE -> HOLD on any transfer; hold_cnt <= HOLD_TICKS.
//   HOLD: hold_cnt decrements on each refresh_en; at refresh_en with hold_cnt==1
//    -> IDLE next cycle. Only current owner's ready may be high; its update
//    changes digits but does not restart hold_cnt. Other requester waits.
//   Owner update in the expiry cycle: accepted, state still -> IDLE.
//   Transfer coinciding with refresh_en on entry: that strobe not counted.
//  Without the macro: no HOLD state, busy tied 0; every cycle is IDLE arbitration,
//   so two continuously valid requesters alternate each cycle.
// CONFIGURATION
//  SSEG_CTRL_HOLD_EN: defined -> HOLD state, hold_cnt, busy as above.
//   Undefined -> pure per-cycle round-robin, HOLD_TICKS ignored.
// STRUCTURE
//  Package sseg_ctrl_pkg: state_t enum {IDLE,HOLD}; owner_t enum {OWN_A,OWN_B};
//   digits_t = logic [3:0][3:0]; DATA_W=16.
//  Sub-module sseg_prescaler (param DIV; clk, rst -> tick): refresh strobe source.
//  Elaboration assertions: REFRESH_DIV>=2, HOLD_TICKS>=1.
// TESTING (REFRESH_DIV=4, HOLD_TICKS=2 unless noted)
//  1 Reset release, no requests -> refresh_en pulses every 4th cycle, digits 0,
//    ready low with valids low, owner=0.
//  2 A,B both valid in IDLE from reset, a=16'h1234 b=16'hABCD -> A granted
//    first, digits 1,2,3,4 next cycle, owner=0; B granted after hold expiry.
//  3 HOLD_EN: A owns, B valid throughout -> b_ready low until 2 refresh strobes
//    counted, then B accepted, digits A,B,C,D, owner=1, busy=1.
//  4 HOLD_EN: A owns, sends 16'h5678 mid-hold -> digits 5,6,7,8 next cycle,
//    IDLE still reached after original 2 strobes.
//  5 rst asserted mid-HOLD -> next cycle digits 0, busy 0, owner 0, A wins tie.
//  6 HOLD_EN undefined: both valid continuously -> grants alternate A,B,A,B each
//    cycle, digits follow with 1-cycle latency, busy stays 0.

Source files
------------

// File: rtl/sseg_ctrl_pkg.sv
// rtl/sseg_ctrl_pkg.sv - shared types and constants for the seven-segment ownership controller
package sseg_ctrl_pkg;
    localparam int DATA_W = 16;

    typedef enum logic {IDLE, HOLD} state_t;
    typedef enum logic {OWN_A, OWN_B} owner_t;
    typedef logic [3:0][3:0] digits_t;
endpackage

// File: rtl/sseg_prescaler.sv
// rtl/sseg_prescaler.sv - free-running divider producing the one-cycle display refresh strobe
module sseg_prescaler
    import sseg_ctrl_pkg::*;
#(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // tick is registered, so it lands in the cycle after cnt hits LAST
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sseg_ctrl.sv
// rtl/sseg_ctrl.sv - round-robin display ownership controller; SSEG_CTRL_HOLD_EN adds the minimum-hold timer
module sseg_ctrl
    import sseg_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int HOLD_TICKS  = 250
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [3:0]        digit3,
    output logic [3:0]        digit2,
    output logic [3:0]        digit1,
    output logic [3:0]        digit0,
    output logic              refresh_en,
    output logic              owner,
    output logic              busy
);
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("sseg_ctrl: REFRESH_DIV must be >= 2");
    end
    if (HOLD_TICKS < 1) begin : g_bad_hold
        $error("sseg_ctrl: HOLD_TICKS must be >= 1");
    end

    logic    tick;
    digits_t digits;
    owner_t  owner_q;
    owner_t  last_grant;
    logic    a_win, b_win;
    logic    a_xfer, b_xfer;

    sseg_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // On a tie the requester that did not win last time goes first
    always_comb begin
        a_win = a_valid && (!b_valid || last_grant == OWN_B);
        b_win = b_valid && (!a_valid || last_grant == OWN_A);
    end

`ifdef SSEG_CTRL_HOLD_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);

    state_t        state;
    logic [HW-1:0] hold_cnt;

    // While held, only the current owner may refresh its own word
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                a_ready = a_win;
                b_ready = b_win;
            end else begin
                a_ready = a_valid && (last_grant == OWN_A);
                b_ready = b_valid && (last_grant == OWN_B);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_xfer || b_xfer) begin
                        state    <= HOLD;
                        hold_cnt <= HW'(HOLD_TICKS);
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_cnt == HW'(1)) state <= IDLE;
                        else                    hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == HOLD);
`else
    always_comb begin
        a_ready = !rst && a_win;
        b_ready = !rst && b_win;
    end

    assign busy = 1'b0;
`endif

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            digits     <= '0;
            owner_q    <= OWN_A;
            last_grant <= OWN_B;
        end else if (a_xfer) begin
            digits     <= digits_t'(a_data);
            owner_q    <= OWN_A;
            last_grant <= OWN_A;
        end else if (b_xfer) begin
            digits     <= digits_t'(b_data);
            owner_q    <= OWN_B;
            last_grant <= OWN_B;
        end
    end

    assign digit3     = digits[3];
    assign digit2     = digits[2];
    assign digit1     = digits[1];
    assign digit0     = digits[0];
    assign refresh_en = tick;
    assign owner      = (owner_q == OWN_B);
endmodule

// File: tb/tb_sseg_ctrl.sv
// tb/tb_sseg_ctrl.sv - scoreboard bench for sseg_ctrl (REFRESH_DIV=4, HOLD_TICKS=2)
module tb_sseg_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic        refresh_en, owner, busy;

    always #5 clk = ~clk;

    sseg_ctrl #(.REFRESH_DIV(4), .HOLD_TICKS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .digit3     (digit3),
        .digit2     (digit2),
        .digit1     (digit1),
        .digit0     (digit0),
        .refresh_en (refresh_en),
        .owner      (owner),
        .busy       (busy)
    );

    typedef struct {
        logic        side;
        logic [15:0] data;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_item;
    logic pend = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic side, input logic [15:0] data, input logic bsy);
        exp_t e;
        e.side = side;
        e.data = data;
        e.busy = bsy;
        exp_q.push_back(e);
    endtask

    // Monitor: pops an expectation on every transfer, checks the latched digits one cycle later
    initial begin
        forever begin
            @(negedge clk);
            if (pend) begin
                check("digits", {digit3, digit2, digit1, digit0}, pend_item.data);
                check("owner", owner, pend_item.side);
                check("busy_after_xfer", busy, pend_item.busy);
                pend = 1'b0;
            end
            if ((a_valid && a_ready) || (b_valid && b_ready)) begin
                check("single_ready", a_ready && b_ready, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: a_ready=%0b b_ready=%0b", a_ready, b_ready);
                end else begin
                    pend_item = exp_q.pop_front();
                    check("grant_side", b_valid && b_ready, pend_item.side);
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        int strobes;
        int got;
        int phase;
        int n;

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        check("rst_refresh", refresh_en, 0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("refresh_period", refresh_en, (i % 4) == 0);
        end

`ifdef SSEG_CTRL_HOLD_EN
        // A wins the first tie; B has to wait out two refresh strobes
        push(1'b0, 16'h1234, 1'b1);
        push(1'b1, 16'hABCD, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b1; a_data = 16'h1234; b_valid = 1'b1; b_data = 16'hABCD;
        @(posedge clk); #1;
        a_valid = 1'b0;
        strobes = 0; got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            @(negedge clk);
            if (b_ready) got = 1;
            else if (refresh_en) strobes++;
        end
        check("b_granted", got, 1);
        check("strobes_before_b", strobes, 2);
        @(posedge clk); #1;
        b_valid = 1'b0;
        wait_idle("b_hold_expired");

        // Owner update mid-hold must not restart the hold timer
        push(1'b0, 16'h4321, 1'b1);
        push(1'b0, 16'h5678, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b1; a_data = 16'h4321;
        @(posedge clk); #1;
        a_valid = 1'b0;
        strobes = 0; phase = 0; n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (!busy) break;
            if (refresh_en) strobes++;
            @(posedge clk); #1;
            if (phase == 1) begin
                a_valid = 1'b0;
                phase = 2;
            end
            if (strobes == 1 && phase == 0) begin
                a_valid = 1'b1; a_data = 16'h5678;
                phase = 1;
            end
        end
        check("mid_hold_update_sent", phase, 2);
        check("hold_strobes_unchanged", strobes, 2);
        check("idle_after_update", busy, 0);

        // Reset in the middle of a hold
        push(1'b0, 16'h1234, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b1; a_data = 16'h1234;
        @(posedge clk); #1;
        a_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midhold_rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("midhold_rst_busy", busy, 0);
        check("midhold_rst_owner", owner, 0);
        push(1'b0, 16'h9ABC, 1'b1);
        @(posedge clk); #1;
        a_valid = 1'b1; a_data = 16'h9ABC; b_valid = 1'b1; b_data = 16'hABCD;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_idle("final_hold_expired");
`else
        // Both valid continuously: strict per-cycle alternation starting with A
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 16'h1234, 1'b0);
            push(1'b1, 16'hABCD, 1'b0);
        end
        @(posedge clk); #1;
        a_valid = 1'b1; a_data = 16'h1234; b_valid = 1'b1; b_data = 16'hABCD;
        repeat (6) @(posedge clk);
        #1 a_valid = 1'b0; b_valid = 1'b0;

        // Lone requester A, then a tie which B must win
        push(1'b0, 16'h5678, 1'b0);
        @(posedge clk); #1;
        a_valid = 1'b1; a_data = 16'h5678;
        @(posedge clk); #1;
        a_valid = 1'b0;
        push(1'b1, 16'hABCD, 1'b0);
        push(1'b0, 16'h5678, 1'b0);
        @(posedge clk); #1;
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 a_valid = 1'b0; b_valid = 1'b0;

        // Reset with both valid: nothing accepted, then A wins the tie again
        repeat (2) @(posedge clk);
        #1;
        push(1'b0, 16'h1234, 1'b0);
        push(1'b1, 16'hABCD, 1'b0);
        rst = 1'b1; a_valid = 1'b1; a_data = 16'h1234; b_valid = 1'b1; b_data = 16'hABCD;
        @(negedge clk);
        check("ready_in_rst_a", a_ready, 0);
        check("ready_in_rst_b", b_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("post_rst_owner", owner, 0);
        repeat (2) @(posedge clk);
        #1 a_valid = 1'b0; b_valid = 1'b0;
`endif

        n = 0;
        while ((exp_q.size() != 0 || pend) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
